// File: rtl/i2c_master_fifo_writer_if.sv
// i2c_master_fifo_writer_if: control, FIFO read-side and open-drain pad signals
// of the I2C write engine. master = the engine, slave = its surroundings.
interface i2c_master_fifo_writer_if;
   logic       start;
   logic [6:0] slave_addr;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_rd;
   logic       scl_o;
   logic       sda_oe;
   logic       sda_i;
   logic       busy;
   logic       done;
   logic       nack_err;

   modport master (
      input  start, slave_addr, fifo_empty, fifo_data, sda_i,
      output fifo_rd, scl_o, sda_oe, busy, done, nack_err
   );

   modport slave (
      output start, slave_addr, fifo_empty, fifo_data, sda_i,
      input  fifo_rd, scl_o, sda_oe, busy, done, nack_err
   );
endinterface

// File: rtl/i2c_master_fifo_writer.sv
// i2c_master_fifo_writer: I2C write engine draining the TX byte FIFO onto SCL/SDA.
// Each bit is four quarters of CLK_DIV clocks; SCL low in Q0/Q1, high in Q2/Q3.
module i2c_master_fifo_writer #(
   parameter int CLK_DIV = 250
) (
   input  logic                     clk,
   input  logic                     reset,
   i2c_master_fifo_writer_if.master bus
);
   // state    | meaning
   // IDLE     | bus released, waiting for start
   // START    | SDA low while SCL high for one quarter
   // ADDR     | shifting {slave_addr, W} MSB first
   // ADDR_ACK | SDA released, slave ACK sampled at start of Q2
   // LOAD     | one cycle: pop next byte, or head for STOP when FIFO empty
   // DATA     | shifting a FIFO byte MSB first
   // DATA_ACK | SDA released, slave ACK sampled at start of Q2
   // STOP     | SCL low/SDA low, SCL high, then SDA released
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_LOAD, S_DATA, S_DATA_ACK, S_STOP
   } state_t;

   localparam int            QW     = $clog2(CLK_DIV);
   localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

   state_t        state;
   logic [QW-1:0] qcnt;
   logic [1:0]    phase;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          ack_bit;
   logic          q_tc;

   assign q_tc = (qcnt == '0);

   // The pop must land on the same edge that captures fifo_data, so it is decoded from state.
   assign bus.fifo_rd = (state == S_LOAD) && !bus.fifo_empty;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_IDLE;
         qcnt         <= '0;
         phase        <= 2'd0;
         bit_cnt      <= 3'd0;
         shreg        <= 8'h00;
         ack_bit      <= 1'b0;
         bus.scl_o    <= 1'b1;
         bus.sda_oe   <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.nack_err <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (state != S_IDLE && state != S_LOAD) begin
            qcnt <= q_tc ? Q_LAST : qcnt - QW'(1);
            if (q_tc) phase <= phase + 2'd1;
         end
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state        <= S_START;
                  shreg        <= {bus.slave_addr, 1'b0};
                  bus.nack_err <= 1'b0;
                  bus.busy     <= 1'b1;
                  bus.sda_oe   <= 1'b1;
                  qcnt         <= Q_LAST;
                  phase        <= 2'd0;
                  bit_cnt      <= 3'd0;
               end
            end
            S_START: begin
               if (q_tc) begin
                  state      <= S_ADDR;
                  bus.scl_o  <= 1'b0;
                  bus.sda_oe <= ~shreg[7];
                  phase      <= 2'd0;
               end
            end
            S_ADDR, S_DATA: begin
               if (q_tc && phase == 2'd1) bus.scl_o <= 1'b1;
               if (q_tc && phase == 2'd3) begin
                  bus.scl_o <= 1'b0;
                  if (bit_cnt == 3'd7) begin
                     bus.sda_oe <= 1'b0;
                     bit_cnt    <= 3'd0;
                     state      <= (state == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                  end else begin
                     bit_cnt    <= bit_cnt + 3'd1;
                     shreg      <= {shreg[6:0], 1'b0};
                     bus.sda_oe <= ~shreg[6];
                  end
               end
            end
            S_ADDR_ACK, S_DATA_ACK: begin
               if (phase == 2'd2 && qcnt == Q_LAST) ack_bit <= bus.sda_i;
               if (q_tc && phase == 2'd1) bus.scl_o <= 1'b1;
               if (q_tc && phase == 2'd3) begin
                  bus.scl_o <= 1'b0;
                  if (ack_bit) begin
                     bus.nack_err <= 1'b1;
                     bus.sda_oe   <= 1'b1;
                     state        <= S_STOP;
                  end else begin
                     state <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               qcnt    <= Q_LAST;
               phase   <= 2'd0;
               bit_cnt <= 3'd0;
               if (bus.fifo_empty) begin
                  bus.sda_oe <= 1'b1;
                  state      <= S_STOP;
               end else begin
                  shreg      <= bus.fifo_data;
                  bus.sda_oe <= ~bus.fifo_data[7];
                  state      <= S_DATA;
               end
            end
            S_STOP: begin
               if (q_tc) begin
                  if (phase == 2'd0) begin
                     bus.scl_o <= 1'b1;
                  end else if (phase == 2'd1) begin
                     bus.sda_oe <= 1'b0;
                  end else begin
                     state    <= S_IDLE;
                     bus.busy <= 1'b0;
                     bus.done <= 1'b1;
                     phase    <= 2'd0;
                     qcnt     <= '0;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
